dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single data-memory port (DataMem address/data/op/we) between the CPU load/store path and a secondary bus master, e.g. a character-memory blit or copy engine. It sits between the requesters and the memory/MMU decode. Requester 0 (CPU) has default priority. Requester 1 gets bounded starvation relief and short locked bursts. Memory reads have one-cycle latency, and the arbiter returns read data to the owning requester.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, cycles requester 1 may wait while requester 0 wins before it is forced through (≥1)
- `MAX_BURST`, 4, maximum consecutive locked grants to requester 1 (≥1)

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `r0_req`, `r1_req`  in  1  request valid; must hold stable with its fields until granted
- `r0_we`, `r1_we`  in  1  write enable
- `r0_op`, `r1_op`  in  3  memop (RV32 funct3 encoding)
- `r0_addr`, `r1_addr`  in  ADDR_W  byte address
- `r0_wdata`, `r1_wdata`  in  DATA_W  store data
- `r1_lock`  in  1  request continuation of a locked burst after this beat
- `r0_gnt`, `r1_gnt`  out  1  access issued this cycle (combinational)
- `r0_rvalid`, `r1_rvalid`  out  1  read data valid this cycle
- `r0_rdata`, `r1_rdata`  out  DATA_W  read data
- `mem_en`  out  1  access issued
- `mem_we`  out  1  write strobe
- `mem_op`  out  3  memop
- `mem_addr`  out  ADDR_W  address
- `mem_wdata`  out  DATA_W  store data
- `mem_rdata`  in  DATA_W  read data, valid one cycle after issue
- `starved`  out  1  starvation counter saturated (debug)

## Operation
- At most one grant per cycle. A requester is granted only if its `req`=1.
- Winner decision, highest rule first:
  1. Requester 1 wins if its burst is active and `r1_req`=1.
  2. Requester 1 wins if `starve_cnt`==STARVE_LIMIT and `r1_req`=1.
  3. Otherwise requester 0 wins if `r0_req`=1.
  4. Otherwise requester 1 wins if `r1_req`=1.
- `mem_*` outputs are the winner's fields. With no grant: `mem_en`=`mem_we`=0, and addr/wdata/op are 0.
- `starve_cnt` (0..STARVE_LIMIT):
  - increments, saturating, when `r1_req` && !`r1_gnt`;
  - clears when `r1_gnt` or !`r1_req`.
  - `starved` = (`starve_cnt`==STARVE_LIMIT).
- Burst state machine, states IDLE and BURST1, with `burst_cnt` 0..MAX_BURST:
  - IDLE→BURST1 on `r1_gnt` && `r1_lock` when MAX_BURST>1; `burst_cnt`←1.
  - In BURST1, each `r1_gnt` increments `burst_cnt`.
  - BURST1→IDLE, clearing `burst_cnt`, when any of these holds:
    - `r1_gnt` with `r1_lock`=0;
    - `r1_req`=0;
    - `r1_gnt` while `burst_cnt`+1==MAX_BURST.
  - On exit, if `r0_req`=1 the next cycle goes to requester 0 (rule 3), unless rule 2 applies. Rule 2 cannot apply on that cycle because `starve_cnt` was cleared by the grant.
- `rN_rvalid` is registered: `rN_gnt` && !`rN_we` from the previous cycle. Writes never raise rvalid.
- `rN_rdata` = `mem_rdata` (combinational pass-through). It is meaningful only while `rN_rvalid`=1.

## Timing
- Grant is combinational in the request cycle. Memory samples on the following rising edge. Read data and rvalid arrive exactly one cycle later.
- Back-to-back grants every cycle are supported, including alternating owners. Read responses pipeline 1:1.
- Reset values: `rN_gnt`=0 whenever `rN_req`=0. All registered outputs are 0: `rN_rvalid`=0, `starved`=0. State is IDLE, with `starve_cnt`=`burst_cnt`=0.
- Reset asserted mid-burst or with a read in flight:
  - all state clears on that edge;
  - the pending rvalid is dropped, with no response delivered;
  - grants stay combinational and are gated off while `reset`=1.
- Simultaneous request and rule change: rules evaluate on the current-cycle registers only. There is no combinational loop from gnt into the counters.

## Structure
- Package `dmem_arb_pkg`:
  - memop constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB/SH/SW reuse the low codes);
  - `req_id_e` {REQ_CPU, REQ_AUX};
  - burst state enum {IDLE, BURST1}.
- One sub-module, `dmem_arb_policy`: holds `starve_cnt`, `burst_cnt` and the FSM, and outputs the winner id. The top level does the field muxing and the rvalid pipeline.

## Test plan
- Only r1 reads addr 0x100 with mem returning 0xDEADBEEF → `r1_gnt` same cycle; next cycle `r1_rvalid`=1, `r1_rdata`=0xDEADBEEF; `r0_rvalid`=0.
- Both request continuously (no lock), STARVE_LIMIT=4 → r0 granted for 4 cycles, `starved`=1, r1 granted in cycle 5, r0 in cycle 6; the pattern repeats.
- r1 with `r1_lock`=1 and r0 contending, MAX_BURST=4 → after r1 wins entry, r1 gets 4 consecutive grants, then r0 is granted next.
- r1 locked burst with `r1_lock` dropped on beat 2 → r1 granted 2 beats, then r0.
- Alternating read r0 / write r1 / read r0 every cycle → `r0_rvalid` in cycles 2 and 4 with the matching data; no `r1_rvalid`; `mem_we`=1 only in cycle 2.
- Reset pulsed during burst beat 2 with a read pending → next cycle all rvalid=0, `starved`=0, IDLE; the first post-reset contention grants r0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and memop encodings for the data-memory port arbiter.
package dmem_arb_pkg;

    // RV32 funct3 memop codes; stores reuse the low load codes
    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;
    localparam logic [2:0] MEMOP_SB  = 3'b000;
    localparam logic [2:0] MEMOP_SH  = 3'b001;
    localparam logic [2:0] MEMOP_SW  = 3'b010;

    typedef enum logic {REQ_CPU, REQ_AUX} req_id_e;

    typedef enum logic {IDLE, BURST1} burst_state_e;

endpackage

// File: rtl/dmem_arb_policy.sv
// Winner selection for the data-memory port: CPU priority, bounded starvation
// relief and locked bursts for the auxiliary master.
module dmem_arb_policy
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    r0_req,
    input  logic    r1_req,
    input  logic    r1_lock,
    output logic    grant,
    output req_id_e winner,
    output logic    starved
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    burst_state_e  state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt;
    logic          r1_win;
    logic          r1_gnt;

    // Decision uses only current registers and requests, so no loop through gnt
    assign r1_win  = r1_req && (state == BURST1 || starve_cnt == STARVE_MAX || !r0_req);
    assign grant   = !reset && (r0_req || r1_req);
    assign winner  = r1_win ? REQ_AUX : REQ_CPU;
    assign r1_gnt  = grant && r1_win;
    assign starved = (starve_cnt == STARVE_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            if (!r1_req || r1_gnt)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + SW'(1);

            case (state)
                IDLE: begin
                    if (r1_gnt && r1_lock && (MAX_BURST > 1)) begin
                        state     <= BURST1;
                        burst_cnt <= BW'(1);
                    end
                end
                BURST1: begin
                    // Leaving the burst hands the next cycle back to normal priority
                    if (!r1_req || (r1_gnt && (!r1_lock || burst_cnt == BURST_LAST))) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (r1_gnt) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU and an auxiliary master,
// muxing request fields and routing one-cycle-latency read responses back.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [2:0]        r0_op,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [2:0]        r1_op,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_lock,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              starved
);

    logic    grant;
    req_id_e winner;
    logic    r0_rd_vld_p1;
    logic    r1_rd_vld_p1;

    dmem_arb_policy #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_BURST    (MAX_BURST)
    ) u_policy (
        .clock   (clock),
        .reset   (reset),
        .r0_req  (r0_req),
        .r1_req  (r1_req),
        .r1_lock (r1_lock),
        .grant   (grant),
        .winner  (winner),
        .starved (starved)
    );

    assign r0_gnt = grant && (winner == REQ_CPU);
    assign r1_gnt = grant && (winner == REQ_AUX);

    // Stage p0: issue the winner's fields to memory
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_op    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r0_gnt) begin
            mem_en    = 1'b1;
            mem_we    = r0_we;
            mem_op    = r0_op;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (r1_gnt) begin
            mem_en    = 1'b1;
            mem_we    = r1_we;
            mem_op    = r1_op;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    // Stage p1: read response returns to whoever issued the read
    always_ff @(posedge clock) begin
        if (reset) begin
            r0_rd_vld_p1 <= 1'b0;
            r1_rd_vld_p1 <= 1'b0;
        end else begin
            r0_rd_vld_p1 <= r0_gnt && !r0_we;
            r1_rd_vld_p1 <= r1_gnt && !r1_we;
        end
    end

    assign r0_rvalid = r0_rd_vld_p1;
    assign r1_rvalid = r1_rd_vld_p1;
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with STARVE_LIMIT=4 and MAX_BURST=4.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r1_req, r1_we, r1_lock;
    logic [2:0]  r0_op, r1_op;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_en, mem_we;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        starved;

    int total  = 0;
    int passed = 0;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .MAX_BURST(4)
    ) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_op(r0_op), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_op(r1_op), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_lock(r1_lock),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .starved(starved)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic idle_all();
        r0_req = 0; r0_we = 0; r0_op = MEMOP_LW; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_op = MEMOP_LW; r1_addr = 0; r1_wdata = 0;
        r1_lock = 0;
    endtask

    initial begin
        logic exp_r1;
        reset = 1'b1;
        mem_rdata = '0;
        idle_all();

        // Reset: grants gated, registered outputs zero
        tick(); tick();
        r0_req = 1; r0_addr = 32'h10;
        sample();
        chk("rst_r0_gnt", 32'(r0_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_starved", 32'(starved), 0);
        chk("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
        tick();
        reset = 1'b0;
        idle_all();

        // Lone r1 read
        r1_req = 1; r1_addr = 32'h100; r1_op = MEMOP_LW;
        sample();
        chk("t1_r1_gnt", 32'(r1_gnt), 1);
        chk("t1_r0_gnt", 32'(r0_gnt), 0);
        chk("t1_mem_en", 32'(mem_en), 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_op", 32'(mem_op), 32'(MEMOP_LW));
        tick();
        idle_all();
        mem_rdata = 32'hDEADBEEF;
        sample();
        chk("t1_r1_rvalid", 32'(r1_rvalid), 1);
        chk("t1_r1_rdata", r1_rdata, 32'hDEADBEEF);
        chk("t1_r0_rvalid", 32'(r0_rvalid), 0);
        chk("t1_idle_mem_en", 32'(mem_en), 0);
        chk("t1_idle_mem_addr", mem_addr, 0);
        tick();
        sample();
        chk("t1_rvalid_drop", 32'(r1_rvalid), 0);
        tick();

        // Continuous contention: r0 x4, then r1 once when starved
        r0_req = 1; r0_addr = 32'h10;
        r1_req = 1; r1_addr = 32'h20;
        for (int k = 1; k <= 10; k++) begin
            exp_r1 = (k % 5 == 0);
            sample();
            chk($sformatf("t2_r0_gnt_c%0d", k), 32'(r0_gnt), 32'(!exp_r1));
            chk($sformatf("t2_r1_gnt_c%0d", k), 32'(r1_gnt), 32'(exp_r1));
            chk($sformatf("t2_starved_c%0d", k), 32'(starved), 32'(exp_r1));
            chk($sformatf("t2_addr_c%0d", k), mem_addr, exp_r1 ? 32'h20 : 32'h10);
            tick();
        end
        idle_all();
        tick();

        // Locked burst of 4 with r0 contending from beat 2
        r1_req = 1; r1_lock = 1; r1_addr = 32'h200;
        for (int k = 1; k <= 5; k++) begin
            sample();
            chk($sformatf("t3_r1_gnt_c%0d", k), 32'(r1_gnt), 32'(k <= 4));
            chk($sformatf("t3_r0_gnt_c%0d", k), 32'(r0_gnt), 32'(k == 5));
            tick();
            r0_req = 1; r0_addr = 32'h30;
        end
        idle_all();
        tick();

        // Lock dropped on beat 2
        r1_req = 1; r1_lock = 1;
        sample();
        chk("t4_b1_r1_gnt", 32'(r1_gnt), 1);
        tick();
        r0_req = 1; r1_lock = 0;
        sample();
        chk("t4_b2_r1_gnt", 32'(r1_gnt), 1);
        chk("t4_b2_r0_gnt", 32'(r0_gnt), 0);
        tick();
        sample();
        chk("t4_c3_r0_gnt", 32'(r0_gnt), 1);
        chk("t4_c3_r1_gnt", 32'(r1_gnt), 0);
        tick();
        idle_all();
        tick();

        // Alternating r0 read / r1 write / r0 read
        r0_req = 1; r0_addr = 32'h40;
        sample();
        chk("t5_c1_r0_gnt", 32'(r0_gnt), 1);
        chk("t5_c1_mem_we", 32'(mem_we), 0);
        tick();
        idle_all();
        r1_req = 1; r1_we = 1; r1_op = MEMOP_SW; r1_addr = 32'h80; r1_wdata = 32'h12345678;
        mem_rdata = 32'hAAAA0001;
        sample();
        chk("t5_c2_r1_gnt", 32'(r1_gnt), 1);
        chk("t5_c2_mem_we", 32'(mem_we), 1);
        chk("t5_c2_mem_wdata", mem_wdata, 32'h12345678);
        chk("t5_c2_r0_rvalid", 32'(r0_rvalid), 1);
        chk("t5_c2_r0_rdata", r0_rdata, 32'hAAAA0001);
        tick();
        idle_all();
        r0_req = 1; r0_addr = 32'h44;
        sample();
        chk("t5_c3_mem_we", 32'(mem_we), 0);
        chk("t5_c3_mem_addr", mem_addr, 32'h44);
        chk("t5_c3_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
        tick();
        idle_all();
        mem_rdata = 32'hAAAA0002;
        sample();
        chk("t5_c4_r0_rvalid", 32'(r0_rvalid), 1);
        chk("t5_c4_r0_rdata", r0_rdata, 32'hAAAA0002);
        chk("t5_c4_r1_rvalid", 32'(r1_rvalid), 0);
        tick();

        // Reset during burst beat 2 with a read pending
        r1_req = 1; r1_lock = 1; r1_addr = 32'h300;
        sample();
        chk("t6_b1_r1_gnt", 32'(r1_gnt), 1);
        tick();
        r0_req = 1; r0_addr = 32'h50;
        reset = 1'b1;
        sample();
        chk("t6_rst_r1_gnt", 32'(r1_gnt), 0);
        chk("t6_rst_mem_en", 32'(mem_en), 0);
        tick();
        reset = 1'b0;
        sample();
        chk("t6_post_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
        chk("t6_post_starved", 32'(starved), 0);
        chk("t6_post_r0_gnt", 32'(r0_gnt), 1);
        chk("t6_post_r1_gnt", 32'(r1_gnt), 0);
        tick();
        idle_all();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
